// File: rtl/gate_meas_pkg.sv
// Shared types and constants for the gated Tosc measurement scheduler.
package gate_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [7:0] CNT_SAT = 8'd255;

endpackage

// File: rtl/tosc_edge_cnt.sv
// Tosc synchronizer, rising-edge detector and saturating 8-bit edge counter.
module tosc_edge_cnt
  import gate_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       Tosc,
  input  logic       cnt_clr,
  input  logic       cnt_en,
  output logic [7:0] count,
  output logic       sat
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_det;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign sat      = (count == CNT_SAT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Tosc};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (cnt_clr)
        count <= '0;
      else if (cnt_en && edge_det && !sat)
        count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/gate_meas_sched.sv
// Round-robin scheduler for two requesters sharing one gated Tosc edge counter.
module gate_meas_sched
  import gate_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLW         = 10
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           Tosc,
  input  logic [1:0]     req,
  input  logic [GLW-1:0] gate_len0,
  input  logic [GLW-1:0] gate_len1,
  output logic [1:0]     grant,
  output logic           busy,
  output logic [7:0]     Dout,
  output logic           dout_id,
  output logic           dout_valid,
  input  logic           dout_ack,
  output logic           ovf
);

  localparam logic [GLW:0] GCNT_ONE = (GLW+1)'(1);
  localparam logic [GLW:0] GCNT_MAX = {1'b1, {GLW{1'b0}}};

  state_e       state_q, state_d;
  logic         last_q;
  logic         win_q;
  logic         win;
  logic         start;
  logic [GLW:0] gcnt_q;
  logic [GLW:0] gate_n;
  logic [GLW-1:0] len_sel;
  logic [7:0]   dout_q;
  logic         id_q;
  logic [1:0]   grant_c;
  logic [7:0]   cnt;
  logic         sat;

  // On a tie the requester not served last wins.
  assign win     = (req == 2'b11) ? ~last_q : req[1];
  assign start   = (state_q == IDLE) && (|req);
  assign len_sel = win ? gate_len1 : gate_len0;
  assign gate_n  = (len_sel == '0) ? GCNT_MAX : {1'b0, len_sel};

  always_comb begin
    state_d = state_q;
    grant_c = '0;
    case (state_q)
      IDLE: if (|req) begin
        grant_c[win] = 1'b1;
        state_d      = GATE;
      end
      GATE: if (gcnt_q == GCNT_ONE) state_d = HOLD;
      HOLD: if (dout_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      gcnt_q  <= '0;
      dout_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        last_q <= win;
        win_q  <= win;
        gcnt_q <= gate_n;
      end else if (state_q == GATE) begin
        gcnt_q <= gcnt_q - GCNT_ONE;
      end
      if (state_q == HOLD) begin
        dout_q <= cnt;
        id_q   <= win_q;
      end
    end
  end

  // The final gate cycle's edge lands in cnt on HOLD entry, so HOLD shows cnt
  // directly and the held copy covers every other state.
  assign grant      = clr ? grant_c : 2'b00;
  assign busy       = (state_q != IDLE);
  assign dout_valid = (state_q == HOLD);
  assign Dout       = dout_valid ? cnt : dout_q;
  assign dout_id    = dout_valid ? win_q : id_q;
  assign ovf        = sat;

  tosc_edge_cnt #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cnt (
    .clk    (clk),
    .clr    (clr),
    .Tosc   (Tosc),
    .cnt_clr(start),
    .cnt_en (state_q == GATE),
    .count  (cnt),
    .sat    (sat)
  );

endmodule

// File: tb/tb_gate_meas_sched.sv
// Directed bench for gate_meas_sched: reset, round-robin, gate timing, saturation, hold, abort.
module tb_gate_meas_sched;

  localparam int GLW = 10;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic           Tosc = 1'b0;
  logic [1:0]     req = 2'b00;
  logic [GLW-1:0] gate_len0 = '0;
  logic [GLW-1:0] gate_len1 = '0;
  logic [1:0]     grant;
  logic           busy;
  logic [7:0]     Dout;
  logic           dout_id;
  logic           dout_valid;
  logic           dout_ack = 1'b0;
  logic           ovf;

  int n_cmp = 0;
  int n_err = 0;
  int tosc_half = 0;

  gate_meas_sched #(.SYNC_STAGES(2), .GLW(GLW)) dut (
    .clk       (clk),
    .clr       (clr),
    .Tosc      (Tosc),
    .req       (req),
    .gate_len0 (gate_len0),
    .gate_len1 (gate_len1),
    .grant     (grant),
    .busy      (busy),
    .Dout      (Dout),
    .dout_id   (dout_id),
    .dout_valid(dout_valid),
    .dout_ack  (dout_ack),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Tosc toggles only on multiples of 10, i.e. on falling clk edges, never racing the sampling edge.
  initial begin
    forever begin
      if (tosc_half == 0) @(negedge clk);
      else begin
        #(tosc_half);
        Tosc = ~Tosc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Serve one transaction starting at a falling edge: grant, gate, optional held HOLD, ack.
  task automatic do_txn(input logic [1:0] exp_g, input bit drop, input int exp_active,
                        input int hold_cyc, output logic [7:0] d_seen, output logic o_seen);
    int   active;
    int   extra;
    int   changes;
    bit   got_g;
    bit   got_v;
    logic [7:0] d0;
    d_seen = '0;
    o_seen = 1'b0;
    got_g  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (grant != 2'b00) begin
        got_g = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", 32'(got_g), 32'd1);
    if (!got_g) return;
    chk("grant", 32'(grant), 32'(exp_g));
    active = 1;
    extra  = 0;
    got_v  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      if (dout_valid) begin
        got_v = 1'b1;
        break;
      end
      if (busy) active++;
      if (grant != 2'b00) extra++;
      @(negedge clk);
    end
    chk("valid_seen", 32'(got_v), 32'd1);
    if (!got_v) return;
    chk("gate_cycles", 32'(active), 32'(exp_active));
    chk("extra_grants", 32'(extra), 32'd0);
    chk("dout_id", 32'(dout_id), 32'(exp_g[1]));
    d_seen  = Dout;
    o_seen  = ovf;
    d0      = Dout;
    changes = 0;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      if (!dout_valid || Dout !== d0 || dout_id !== exp_g[1]) changes++;
    end
    if (hold_cyc > 0) chk("hold_stable", 32'(changes), 32'd0);
    dout_ack = 1'b1;
    if (drop) req = 2'b00;
    @(negedge clk);
    dout_ack = 1'b0;
    chk("valid_after_ack", 32'(dout_valid), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  logic [7:0] d;
  logic       o;
  int         bad;
  bit         got_g;

  initial begin
    // Reset with requests pending: nothing may be granted.
    req = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_id", 32'(dout_id), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    req = 2'b00;
    clr = 1'b1;
    @(negedge clk);

    // Round-robin with both requests held across three transactions.
    gate_len0 = 10'd8;
    gate_len1 = 10'd8;
    req = 2'b11;
    do_txn(2'b01, 1'b0, 9, 0, d, o);
    do_txn(2'b10, 1'b0, 9, 0, d, o);
    do_txn(2'b01, 1'b1, 9, 0, d, o);
    chk("rr_dout_no_tosc", 32'(d), 32'd0);

    // 60-cycle gate on a 60-unit Tosc period: 10 rising edges.
    tosc_half = 30;
    gate_len0 = 10'd60;
    req = 2'b01;
    do_txn(2'b01, 1'b1, 61, 0, d, o);
    chk("g60_dout_range", 32'(d >= 8'd9 && d <= 8'd10), 32'd1);
    chk("g60_ovf", 32'(o), 32'd0);
    chk("g60_dout_kept", 32'(Dout >= 8'd9 && Dout <= 8'd10), 32'd1);

    // Length 0 means 1024 cycles; 512 edges must saturate at 255.
    tosc_half = 10;
    gate_len1 = 10'd0;
    req = 2'b10;
    do_txn(2'b10, 1'b1, 1025, 0, d, o);
    chk("sat_dout", 32'(d), 32'd255);
    chk("sat_ovf", 32'(o), 32'd1);

    // Spurious ack and a gate_len change mid-gate, then a 20-cycle withheld ack.
    tosc_half = 30;
    gate_len0 = 10'd20;
    req = 2'b01;
    fork
      do_txn(2'b01, 1'b1, 21, 20, d, o);
      begin
        repeat (5) @(negedge clk);
        dout_ack  = 1'b1;
        gate_len0 = 10'd5;
        @(negedge clk);
        dout_ack  = 1'b0;
        chk("spurious_ack_busy", 32'(busy), 32'd1);
        chk("spurious_ack_valid", 32'(dout_valid), 32'd0);
      end
    join
    chk("g20_ovf_cleared", 32'(o), 32'd0);
    chk("g20_dout_range", 32'(d >= 8'd3 && d <= 8'd4), 32'd1);

    // Abort mid-gate with clr; requester 0 was served last before the abort.
    gate_len0 = 10'd50;
    req = 2'b01;
    got_g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (grant != 2'b00) begin
        got_g = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_grant_seen", 32'(got_g), 32'd1);
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    clr = 1'b0;
    req = 2'b00;
    #1;
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", 32'(Dout), 32'd0);
    chk("abort_id", 32'(dout_id), 32'd0);
    chk("abort_valid", 32'(dout_valid), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (dout_valid || busy) bad++;
    end
    chk("abort_no_result", 32'(bad), 32'd0);

    // Pointer is back to "last served = 1", so the tie goes to requester 0.
    tosc_half = 0;
    gate_len0 = 10'd4;
    gate_len1 = 10'd4;
    req = 2'b11;
    do_txn(2'b01, 1'b1, 5, 0, d, o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
